// File: rtl/perf_trace_unit.sv
// perf_trace_unit: execution monitor that counts core events and keeps a FIFO trace of taken-branch PCs
module perf_trace_unit #(
  parameter int CNT_W    = 16,
  parameter int PC_W     = 8,
  parameter int DEPTH    = 8,
  parameter int SATURATE = 1
) (
  input  logic             CLK,
  input  logic             start,
  input  logic             enable,
  input  logic             clear,
  input  logic             retire,
  input  logic             halt,
  input  logic [PC_W-1:0]  PC,
  input  logic             BRANCH,
  input  logic             REG_WRITE,
  input  logic             MEM_WRITE,
  input  logic             trace_rd,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] regwr_count,
  output logic [CNT_W-1:0] memwr_count,
  output logic [PC_W-1:0]  trace_pc,
  output logic             trace_valid,
  output logic             trace_full,
  output logic             trace_overflow,
  output logic             running,
  output logic             stopped
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state, state_nxt;
  logic cnt_run, ev_ret, push, pop, wr_en, ovf_set;
  logic [AW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [AW:0] occ, occ_nxt;
  logic [PC_W-1:0] head_nxt;
  logic [PC_W-1:0] mem [DEPTH];

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic en);
    return !en ? c : (SATURATE != 0 && &c) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge CLK or posedge start)
    if (start) begin
      state   <= IDLE;
      running <= 1'b0;
      stopped <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= state_nxt == RUN;
      stopped <= state_nxt == HALTED;
    end

  always_comb
    state_nxt = clear ? IDLE :
                (state == IDLE && enable) ? RUN :
                (state == RUN && halt) ? HALTED : state;

  // clear suppresses every event and pop in its cycle
  always_comb begin
    cnt_run  = state == RUN && !clear;
    ev_ret   = cnt_run && retire;
    push     = ev_ret && BRANCH;
    pop      = !clear && trace_rd && trace_valid;
    wr_en    = push && (!trace_full || pop);
    ovf_set  = push && trace_full && !pop;
    wr_nxt   = wr_ptr + AW'(wr_en);
    rd_nxt   = rd_ptr + AW'(pop);
    occ_nxt  = occ + (AW+1)'(wr_en) - (AW+1)'(pop);
    head_nxt = !(|occ_nxt) ? '0 : (wr_en && wr_ptr == rd_nxt) ? PC : mem[rd_nxt];
  end

  always_ff @(posedge CLK)
    if (wr_en) mem[wr_ptr] <= PC;

  always_ff @(posedge CLK or posedge start)
    if (start) begin
      cycle_count    <= '0;
      inst_count     <= '0;
      branch_count   <= '0;
      regwr_count    <= '0;
      memwr_count    <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occ            <= '0;
      trace_pc       <= '0;
      trace_valid    <= 1'b0;
      trace_full     <= 1'b0;
      trace_overflow <= 1'b0;
    end else if (clear) begin
      cycle_count    <= '0;
      inst_count     <= '0;
      branch_count   <= '0;
      regwr_count    <= '0;
      memwr_count    <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occ            <= '0;
      trace_pc       <= '0;
      trace_valid    <= 1'b0;
      trace_full     <= 1'b0;
      trace_overflow <= 1'b0;
    end else begin
      cycle_count    <= bump(cycle_count, cnt_run);
      inst_count     <= bump(inst_count, ev_ret);
      branch_count   <= bump(branch_count, ev_ret && BRANCH);
      regwr_count    <= bump(regwr_count, ev_ret && REG_WRITE);
      memwr_count    <= bump(memwr_count, ev_ret && MEM_WRITE);
      wr_ptr         <= wr_nxt;
      rd_ptr         <= rd_nxt;
      occ            <= occ_nxt;
      trace_pc       <= head_nxt;
      trace_valid    <= |occ_nxt;
      trace_full     <= occ_nxt == (AW+1)'(DEPTH);
      trace_overflow <= trace_overflow || ovf_set;
    end
endmodule
